// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//   Turns a raster-order pixel stream into vertical 3-pixel columns for the
//   3x3 systolic convolution array. Two line memories hold the previous two
//   rows. Each accepted pixel produces one registered column one cycle later.
//
// Ports
//   clk, rst     single clock; synchronous active-high reset
//   pix_in       input pixel, accepted when pix_valid && pix_ready
//   pix_valid    pix_in valid
//   pix_sof      start of frame: forces the beat to position (0,0)
//   pix_ready    feeder can take a pixel this cycle
//   col_out      {row y-2, row y-1, row y}; oldest row in MSBs
//   col_valid    col_out valid (only once two full rows are buffered)
//   col_x        image column of col_out
//   win_valid    a full 3x3 window ends at this column (col_x >= 2)
//   row_last     column is the last one of its row
//   frame_done   column is the last one of a complete frame
//   col_ready    downstream accepts col_out
module conv_window_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int X_W        = $clog2(IMG_WIDTH),
  parameter int Y_W        = $clog2(IMG_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_valid,
  input  logic                    pix_sof,
  output logic                    pix_ready,
  output logic [3*DATA_WIDTH-1:0] col_out,
  output logic                    col_valid,
  output logic [X_W-1:0]          col_x,
  output logic                    win_valid,
  output logic                    row_last,
  output logic                    frame_done,
  input  logic                    col_ready
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];  // row y-2
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];  // row y-1

  logic [X_W-1:0] x, cur_x;
  logic [Y_W-1:0] y, cur_y;
  logic           accept, rows_full, x_last, y_last;

  // The output register is a one-deep skid: it can take a new column
  // whenever it is empty or being drained in the same cycle.
  assign pix_ready = !col_valid || col_ready;
  assign accept    = pix_valid && pix_ready;

  // sof relocates this beat to (0,0), abandoning any partial frame.
  assign cur_x     = pix_sof ? '0 : x;
  assign cur_y     = pix_sof ? '0 : y;
  assign rows_full = cur_y >= Y_W'(2);
  assign x_last    = cur_x == X_LAST;
  assign y_last    = cur_y == Y_LAST;

  // Line memories are never cleared; rows 0/1 of every frame overwrite them
  // before they are emitted, because output is gated on y >= 2.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_x] <= lb0[cur_x];
      lb0[cur_x] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      col_out    <= '0;
      col_valid  <= 1'b0;
      col_x      <= '0;
      win_valid  <= 1'b0;
      row_last   <= 1'b0;
      frame_done <= 1'b0;
    end else if (accept) begin
      col_out    <= {lb1[cur_x], lb0[cur_x], pix_in};
      col_x      <= cur_x;
      col_valid  <= rows_full;
      win_valid  <= rows_full && (cur_x >= X_W'(2));
      row_last   <= rows_full && x_last;
      frame_done <= x_last && y_last;  // y_last implies rows_full (H >= 3)
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : cur_y + Y_W'(1);
      end else begin
        x <= cur_x + X_W'(1);
        y <= cur_y;
      end
    end else if (col_ready) begin
      // Retire without replacement; qualifiers drop with col_valid.
      col_valid  <= 1'b0;
      win_valid  <= 1'b0;
      row_last   <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
